// File: rtl/gpio_pkg.sv
// Shared defaults for the GPIO input conditioner and its per-channel filter.
package gpio_pkg;

  localparam int GPIO_WIDTH_DEF    = 32;
  localparam int GPIO_STAGES_DEF   = 2;
  localparam int GPIO_FILTER_W_DEF = 4;

  // Fewer than two synchronizer flops leaves no settling time for metastability.
  localparam int GPIO_MIN_STAGES   = 2;

endpackage

// File: rtl/gpio_filter_bit.sv
// One GPIO channel: synchronizer chain, debounce counter and stable level flop.
module gpio_filter_bit
  import gpio_pkg::*;
#(
  parameter int STAGES   = GPIO_STAGES_DEF,
  parameter int FILTER_W = GPIO_FILTER_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_din,
  input  logic [FILTER_W-1:0] i_filter_len,
  output logic                o_level
);

  if (STAGES < GPIO_MIN_STAGES) begin : g_stages_check
    $error("gpio_filter_bit: STAGES must be at least 2");
  end

  (* async_reg = "true" *) logic [STAGES-1:0] r_sync;
  logic [FILTER_W-1:0] r_cnt;
  logic                r_level;
  logic                w_stage;

  // Shift the raw pad value through the synchronizer chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_din};
    end
  end

  assign w_stage = r_sync[STAGES-1];

  // Debounce: count cycles of disagreement, adopt the new level once the count
  // reaches the filter length. The >= compare lets a shortened length act at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_stage == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt >= i_filter_len) begin
      r_level <= w_stage;
      r_cnt   <= '0;
    end else if (r_cnt != {FILTER_W{1'b1}}) begin
      r_cnt <= r_cnt + {{(FILTER_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-channel synchronize + debounce, optional edge
// pending/interrupt logic enabled by defining GPIO_EDGE_IRQ_EN.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH    = GPIO_WIDTH_DEF,
  parameter int STAGES   = GPIO_STAGES_DEF,
  parameter int FILTER_W = GPIO_FILTER_W_DEF
) (
  input  logic                io_mainClk,
  input  logic                resetCtrl_systemResetn,
  input  logic [WIDTH-1:0]    io_dataIn,
  input  logic [FILTER_W-1:0] io_filterLen,
  input  logic [WIDTH-1:0]    io_riseEn,
  input  logic [WIDTH-1:0]    io_fallEn,
  input  logic [WIDTH-1:0]    io_irqMask,
  input  logic [WIDTH-1:0]    io_pendClr,
  output logic [WIDTH-1:0]    io_dataOut,
  output logic [WIDTH-1:0]    io_pending,
  output logic                io_irq
);

  logic [WIDTH-1:0] w_level;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    gpio_filter_bit #(
      .STAGES   (STAGES),
      .FILTER_W (FILTER_W)
    ) u_filter (
      .i_clk        (io_mainClk),
      .i_rst_n      (resetCtrl_systemResetn),
      .i_din        (io_dataIn[g]),
      .i_filter_len (io_filterLen),
      .o_level      (w_level[g])
    );
  end

  assign io_dataOut = w_level;

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] r_level_d;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_set;

  // Remember the previous stable level so edges show up one cycle later.
  always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
    if (!resetCtrl_systemResetn) begin
      r_level_d <= '0;
    end else begin
      r_level_d <= w_level;
    end
  end

  assign w_set = (io_riseEn & w_level & ~r_level_d) |
                 (io_fallEn & ~w_level & r_level_d);

  // Sticky pending flags; a new edge beats a simultaneous clear.
  always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
    if (!resetCtrl_systemResetn) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~io_pendClr) | w_set;
    end
  end

  assign io_pending = r_pending;
  assign io_irq     = |(r_pending & io_irqMask);
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{io_riseEn, io_fallEn, io_irqMask, io_pendClr};
  assign io_pending   = '0;
  assign io_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner: expectations are queued with the
// cycle at which they must hold and checked just after that clock edge.
module tb_gpio_input_conditioner;

`ifdef GPIO_EDGE_IRQ_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam int SEL_DATA = 0;
  localparam int SEL_PEND = 1;
  localparam int SEL_IRQ  = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [3:0]  flen;
  logic [31:0] rise_en;
  logic [31:0] fall_en;
  logic [31:0] irq_mask;
  logic [31:0] pend_clr;
  logic [31:0] dout;
  logic [31:0] pend;
  logic        irq;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] msk;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  gpio_input_conditioner dut (
    .io_mainClk             (clk),
    .resetCtrl_systemResetn (rst_n),
    .io_dataIn              (din),
    .io_filterLen           (flen),
    .io_riseEn              (rise_en),
    .io_fallEn              (fall_en),
    .io_irqMask             (irq_mask),
    .io_pendClr             (pend_clr),
    .io_dataOut             (dout),
    .io_pending             (pend),
    .io_irq                 (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_at(input int dc, input int sel, input logic [31:0] msk,
                        input logic [31:0] val, input string tag);
    exp_t e;
    e.cyc = cyc + dc;
    e.sel = sel;
    e.msk = msk;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop every expectation due this cycle; anything overdue is reported as late.
  always @(posedge clk) begin
    logic [31:0] got;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].sel)
          SEL_DATA: got = dout;
          SEL_PEND: got = pend;
          default:  got = {31'd0, irq};
        endcase
        if (sb[i].cyc == cyc) chk(sb[i].tag, got & sb[i].msk, sb[i].val);
        else chk({"late_", sb[i].tag}, cyc, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    din      = '0;
    flen     = 4'd0;
    rise_en  = '0;
    fall_en  = '0;
    irq_mask = '1;
    pend_clr = '0;
    for (int d = 1; d <= 3; d++) begin
      exp_at(d, SEL_DATA, '1, '0, "rst_data");
      exp_at(d, SEL_PEND, '1, '0, "rst_pend");
      exp_at(d, SEL_IRQ,  '1, '0, "rst_irq");
    end
    step(3);
    rst_n    = 1'b1;
    irq_mask = '0;
    while (cyc < 10) step(1);

    // N=0: step at cycle 10 appears at cycle 13.
    din[0] = 1'b1;
    exp_at(1, SEL_DATA, 32'h1, 32'h0, "n0_lat_c11");
    exp_at(2, SEL_DATA, 32'h1, 32'h0, "n0_lat_c12");
    exp_at(3, SEL_DATA, 32'h1, 32'h1, "n0_lat_c13");
    step(5);

    // N=3: 3-cycle glitch is rejected, a held level arrives after 6 cycles.
    flen = 4'd3;
    step(1);
    din[5] = 1'b1;
    for (int d = 1; d <= 10; d++) exp_at(d, SEL_DATA, 32'h20, 32'h0, "n3_glitch");
    step(3);
    din[5] = 1'b0;
    step(8);
    din[5] = 1'b1;
    exp_at(5, SEL_DATA, 32'h20, 32'h0,  "n3_hold_early");
    exp_at(6, SEL_DATA, 32'h20, 32'h20, "n3_hold");
    step(8);

    // Rising edge on bit 2, masking, then write-1-to-clear.
    flen     = 4'd0;
    rise_en  = 32'h4;
    irq_mask = 32'h4;
    step(1);
    din[2] = 1'b1;
    exp_at(3, SEL_DATA, 32'h4, 32'h4, "rise_level");
    exp_at(3, SEL_PEND, '1, 32'h0, "rise_pend_early");
    exp_at(4, SEL_PEND, '1, EDGE ? 32'h4 : 32'h0, "rise_pend");
    exp_at(4, SEL_IRQ,  '1, {31'd0, EDGE}, "rise_irq");
    step(4);
    irq_mask = 32'h0;
    exp_at(1, SEL_IRQ,  '1, 32'h0, "masked_irq");
    exp_at(1, SEL_PEND, '1, EDGE ? 32'h4 : 32'h0, "masked_pend");
    step(1);
    irq_mask = 32'h4;
    pend_clr = 32'h4;
    exp_at(1, SEL_PEND, '1, 32'h0, "clr_pend");
    exp_at(1, SEL_IRQ,  '1, 32'h0, "clr_irq");
    step(1);
    pend_clr = '0;
    step(2);

    // Fall on bit 7 coinciding with a clear: the set wins.
    fall_en = 32'h80;
    din[7]  = 1'b1;
    step(5);
    din[7] = 1'b0;
    exp_at(3, SEL_PEND, '1, 32'h0, "fall_pend_early");
    step(3);
    pend_clr = 32'h80;
    exp_at(1, SEL_PEND, '1, EDGE ? 32'h80 : 32'h0, "set_wins");
    exp_at(1, SEL_IRQ,  '1, 32'h0, "fall_irq_masked");
    step(1);
    pend_clr = '0;
    fall_en  = '0;
    exp_at(1, SEL_PEND, '1, EDGE ? 32'h80 : 32'h0, "pend_sticky");
    step(1);
    pend_clr = 32'h80;
    exp_at(1, SEL_PEND, '1, 32'h0, "fall_clr");
    step(1);
    pend_clr = '0;
    step(2);

    // N=15 with count at 10, shorten to N=4: level moves next cycle.
    flen   = 4'd15;
    din[9] = 1'b1;
    exp_at(12, SEL_DATA, 32'h200, 32'h0,   "shorten_before");
    exp_at(13, SEL_DATA, 32'h200, 32'h200, "shorten_after");
    step(12);
    flen = 4'd4;
    step(4);

    // Reset mid-debounce, release with inputs high: full latency again.
    flen    = 4'd3;
    din[11] = 1'b1;
    step(4);
    rst_n = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      exp_at(d, SEL_DATA, '1, '0, "mid_rst_data");
      exp_at(d, SEL_PEND, '1, '0, "mid_rst_pend");
      exp_at(d, SEL_IRQ,  '1, '0, "mid_rst_irq");
    end
    step(3);
    rst_n = 1'b1;
    exp_at(5, SEL_DATA, '1, 32'h0,    "post_rst_early");
    exp_at(6, SEL_DATA, '1, 32'h0A25, "post_rst_lat");
    exp_at(6, SEL_PEND, '1, 32'h0,    "post_rst_pend0");
    exp_at(7, SEL_PEND, '1, EDGE ? 32'h4 : 32'h0, "post_rst_pend");
    exp_at(7, SEL_IRQ,  '1, {31'd0, EDGE}, "post_rst_irq");
    step(10);

    for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
    while (sb.size() != 0) begin
      chk({"unchecked_", sb[0].tag}, cyc, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, 32: number of GPIO input channels.
REQ-003 Parameter STAGES, 2: synchronizer depth; values below 2 are illegal and SHALL fail elaboration.
REQ-004 Parameter FILTER_W, 4: width of the per-channel debounce counter and of io_filterLen.
REQ-005 io_mainClk  input  1: system clock.
REQ-006 resetCtrl_systemResetn  input  1: asynchronous active-low reset.
REQ-007 io_dataIn  input  WIDTH: raw asynchronous pad inputs.
REQ-008 io_filterLen  input  FILTER_W: debounce length N in cycles; 0 = filter bypass.
REQ-009 io_riseEn  input  WIDTH: per-channel rising-edge capture enable.
REQ-010 io_fallEn  input  WIDTH: per-channel falling-edge capture enable.
REQ-011 io_irqMask  input  WIDTH: per-channel interrupt enable.
REQ-012 io_pendClr  input  WIDTH: one-cycle write-1-to-clear strobe for pending bits.
REQ-013 io_dataOut  output  WIDTH: synchronized, debounced level.
REQ-014 io_pending  output  WIDTH: sticky edge-pending flags.
REQ-015 io_irq  output  1: OR of (io_pending AND io_irqMask).

Function
REQ-016 Each channel SHALL pass through STAGES flops in series; all synchronizer flops SHALL carry the async_reg attribute.
REQ-017 Per channel, while the last synchronizer stage equals the stable level, the debounce counter SHALL be zeroed.
REQ-018 While the last stage differs from the stable level, the counter SHALL increment each cycle, saturating at all-ones.
REQ-019 When the stage differs and counter >= io_filterLen, the stable level SHALL take the stage value and the counter SHALL clear in the same cycle.
REQ-020 Latency from a clean input step to io_dataOut SHALL be STAGES+1+N cycles; with N=0, STAGES+1 cycles.
REQ-021 A pulse shorter than N+1 cycles at the last stage SHALL not change io_dataOut.
REQ-022 A reduction of io_filterLen mid-count SHALL take effect next cycle via the >= compare; no wrap-around is permitted.
REQ-023 A pending bit SHALL set the cycle after the stable level rises with io_riseEn=1, or falls with io_fallEn=1.
REQ-024 A pending bit SHALL clear the cycle after io_pendClr=1 for that bit.
REQ-025 When set and clear coincide on one bit, set SHALL win.
REQ-026 io_irq SHALL be combinational from the pending register and io_irqMask; masking SHALL NOT alter io_pending.
REQ-027 Enable and mask changes SHALL affect only subsequent edges; already-pending bits SHALL remain set.

Reset
REQ-028 Asserting reset SHALL asynchronously clear all synchronizer flops, counters, stable levels and pending bits.
REQ-029 During and after reset: io_dataOut=0, io_pending=0, io_irq=0; reset release SHALL be used synchronously.
REQ-030 Reset asserted mid-debounce SHALL discard the count; after release, a high input SHALL count again from zero.

Configuration
REQ-031 With macro GPIO_EDGE_IRQ_EN defined, edge detection, the pending register and io_irq SHALL operate per REQ-023..027.
REQ-032 Without GPIO_EDGE_IRQ_EN, no pending logic SHALL be synthesized: io_pending and io_irq SHALL be tied to 0 and the enable, mask and clear inputs ignored.

Structure
REQ-033 Package gpio_pkg SHALL hold the default values for WIDTH, STAGES and FILTER_W and the minimum-STAGES constant (2).
REQ-034 Sub-module gpio_filter_bit (one synchronizer chain, counter and stable flop) SHALL be instantiated WIDTH times via generate.

Verification
REQ-035 N=0, STAGES=2: bit0 0->1 at cycle 10 -> io_dataOut[0]=1 at cycle 13.
REQ-036 N=3: bit5 glitch high for 3 cycles -> no io_dataOut change; held 6 cycles -> io_dataOut[5]=1 at step+6.
REQ-037 riseEn[2]=1, mask[2]=1: bit2 rises -> io_pending=0x4 and io_irq=1; pendClr=0x4 -> both 0 next cycle.
REQ-038 fallEn[7]=1: a fall coincides with pendClr[7]=1 -> pending[7] stays 1.
REQ-039 N=15 with count at 10, write N=4 -> io_dataOut updates next cycle.
REQ-040 Assert reset mid-debounce, release with input high -> all outputs 0 and a full STAGES+1+N latency is observed; repeat without GPIO_EDGE_IRQ_EN -> io_pending and io_irq are constant 0.
